multicycle_controller: RTL

- Moore-style control FSM that sequences the multi-cycle MIPS datapath: PC/IR register enables, register-file write, source-mux selects and ALU operation, one step per clock.
- Inputs: op, funct and zero from the datapath. Outputs: the datapath control bus plus memwrite to data/instruction memory.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

---
 rtl/multicycle_controller_if.sv | 42 ++++
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_if
//  Description : Control bus between the multi-cycle MIPS controller and its
//                datapath. The datapath supplies op, funct and zero; the
//                controller returns register enables, mux selects, the ALU
//                operation, the memory write strobe and debug state.
//                  master : controller side (drives the control signals)
//                  slave  : datapath side (drives op/funct/zero)
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_controller_if;
    logic [5:0] op;          // instr[31:26]
    logic [5:0] funct;       // instr[5:0]
    logic       zero;        // ALU zero flag, same cycle
    logic       pcen;        // PC register enable
    logic       irwrite;     // instruction register enable
    logic       regwrite;    // register file write enable
    logic       alusrca;     // 0=PC, 1=A
    logic       iord;        // 0=PC address, 1=ALUOut address
    logic       memtoreg;    // 0=ALUOut, 1=data register
    logic       regdst;      // 0=rt, 1=rd
    logic       memwrite;    // memory write strobe
    logic [1:0] alusrcb;     // 00=B, 01=4, 10=signimm, 11=signimm<<2
    logic [1:0] pcsrc;       // 00=ALU result, 01=ALUOut, 10=jump target
    logic [2:0] alucontrol;  // ALU operation
    logic       illegal;     // unsupported op pulse in DECODE
    logic [3:0] state;       // current state, debug only

    modport master (
        input  op, funct, zero,
        output pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               memwrite, alusrcb, pcsrc, alucontrol, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               memwrite, alusrcb, pcsrc, alucontrol, illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore control FSM for the multi-cycle MIPS datapath
//                (lw, sw, R-type add/sub/and/or/slt, beq, addi, j).
//                Ports:
//                  clk   : system clock, rising edge
//                  reset : asynchronous active-high, forces FETCH
//                  bus   : control interface (master modport)
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       memwrite;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctrl_t;

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_slt = 3'b111;

    // R-type ALU operation; unknown funct codes quietly fall back to add.
    function automatic logic [2:0] f_funct_alu(input logic [5:0] fn);
        logic [2:0] a;
        case (fn)
            6'b100000: a = c_alu_add;
            6'b100010: a = c_alu_sub;
            6'b100100: a = c_alu_and;
            6'b100101: a = c_alu_or;
            6'b101010: a = c_alu_slt;
            default:   a = c_alu_add;
        endcase
        return a;
    endfunction

    // Control word for a given state. funct only matters in EXECUTE.
    function automatic ctrl_t f_decode(input state_t s, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite    = 1'b1;
                c.pcwrite    = 1'b1;
                c.alusrcb    = 2'b01;
                c.alucontrol = c_alu_add;
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                c.alusrcb    = 2'b11;
                c.alucontrol = c_alu_add;
            end
            MEMADR: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = c_alu_add;
            end
            MEMRD: begin
                c.iord       = 1'b1;
            end
            MEMWB: begin
                c.memtoreg   = 1'b1;
                c.regwrite   = 1'b1;
            end
            MEMWR: begin
                c.iord       = 1'b1;
                c.memwrite   = 1'b1;
            end
            EXECUTE: begin
                c.alusrca    = 1'b1;
                c.alucontrol = f_funct_alu(fn);
            end
            ALUWB: begin
                c.regdst     = 1'b1;
                c.regwrite   = 1'b1;
            end
            BRANCH: begin
                c.alusrca    = 1'b1;
                c.alucontrol = c_alu_sub;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
            end
            ADDIEX: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = c_alu_add;
            end
            ADDIWB: begin
                c.regwrite   = 1'b1;
            end
            JUMP: begin
                c.pcsrc      = 2'b10;
                c.pcwrite    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    logic   w_op_legal;

    always_comb begin
        case (bus.op)
            c_op_lw, c_op_sw, c_op_rtype,
            c_op_beq, c_op_addi, c_op_j: w_op_legal = 1'b1;
            default:                     w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE: begin
                case (bus.op)
                    c_op_lw, c_op_sw: w_next = MEMADR;
                    c_op_rtype:       w_next = EXECUTE;
                    c_op_beq:         w_next = BRANCH;
                    c_op_addi:        w_next = ADDIEX;
                    c_op_j:           w_next = JUMP;
                    default:          w_next = FETCH;   // skip unsupported op
                endcase
            end
            MEMADR:  w_next = (bus.op == c_op_sw) ? MEMWR : MEMRD;
            MEMRD:   w_next = MEMWB;
            EXECUTE: w_next = ALUWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    // Control word is registered alongside the state by decoding the next
    // state, so outputs are glitch-free yet still a pure function of state.
    // In EXECUTE the funct sampled on entry is used; IR is stable by then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= f_decode(FETCH, 6'd0);
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_decode(w_next, bus.funct);
        end
    end

    // pcen and illegal need live datapath inputs, so they stay combinational.
    assign bus.pcen       = r_ctrl.pcwrite | (r_ctrl.branch & bus.zero);
    assign bus.illegal    = (r_state == DECODE) & ~w_op_legal;
    assign bus.irwrite    = r_ctrl.irwrite;
    assign bus.regwrite   = r_ctrl.regwrite;
    assign bus.alusrca    = r_ctrl.alusrca;
    assign bus.iord       = r_ctrl.iord;
    assign bus.memtoreg   = r_ctrl.memtoreg;
    assign bus.regdst     = r_ctrl.regdst;
    assign bus.memwrite   = r_ctrl.memwrite;
    assign bus.alusrcb    = r_ctrl.alusrcb;
    assign bus.pcsrc      = r_ctrl.pcsrc;
    assign bus.alucontrol = r_ctrl.alucontrol;
    assign bus.state      = r_state;

endmodule
`default_nettype wire
